// File: rtl/spi_link_pkg.sv
// Shared SPI link definitions: word width and bit order, used by both the
// serializer of the output stage and the receiving deserializer.
package spi_link_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam bit          MSB_FIRST = 1'b1;

  typedef logic [WORD_W-1:0] word_t;

  // Returns the shift register value after one more serial bit has arrived.
  function automatic word_t shift_in(word_t sr, logic b);
    return MSB_FIRST ? {sr[WORD_W-2:0], b} : {b, sr[WORD_W-1:1]};
  endfunction

endpackage

// File: rtl/input_process_spi_rx_if.sv
// Serial-in / word-out bundle of input_process_spi_rx. The WORD_CNT and DROP_CNT
// members exist only when SPI_RX_STATS_EN is defined.
interface input_process_spi_rx_if #(
  parameter int unsigned DEPTH = 16
);

  logic                          RX_DATA;
  logic                          RX_LOAD;
  logic                          STOP;
  spi_link_pkg::word_t           DATA;
  logic                          VALID;
  logic                          READY;
  logic                          OVERFLOW;
  logic [$clog2(DEPTH):0]        LEVEL;
`ifdef SPI_RX_STATS_EN
  logic [15:0]                   WORD_CNT;
  logic [15:0]                   DROP_CNT;
`endif

  modport master (
    output RX_DATA, RX_LOAD, READY,
`ifdef SPI_RX_STATS_EN
    input  WORD_CNT, DROP_CNT,
`endif
    input  STOP, DATA, VALID, OVERFLOW, LEVEL
  );

  modport slave (
    input  RX_DATA, RX_LOAD, READY,
`ifdef SPI_RX_STATS_EN
    output WORD_CNT, DROP_CNT,
`endif
    output STOP, DATA, VALID, OVERFLOW, LEVEL
  );

endinterface

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: head word is presented while valid, a write into
// an empty FIFO is visible the cycle after. Full writes without a pop are dropped.
module sync_fifo_sa #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             wr_drop,
  output logic [AW:0]      level,
  output logic [AW:0]      level_next
);

  localparam logic [AW:0] FullLevel = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             full, pop, push;

  assign full    = (level_q == FullLevel);
  assign valid   = (level_q != '0);
  assign pop     = rd_en & valid;
  // A pop in the same cycle frees the slot the write needs.
  assign push    = wr_en & (~full | pop);
  assign wr_drop = wr_en & full & ~pop;
  assign rd_data = valid ? mem_q[rd_ptr_q] : '0;
  assign level   = level_q;

  always_comb begin
    level_next = level_q;
    if (push && !pop) begin
      level_next = level_q + 1'b1;
    end else if (pop && !push) begin
      level_next = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_next;
    end
  end

endmodule

// File: rtl/input_process_spi_rx.sv
// Deserializes the SPI output stream into words, buffers them in a show-ahead FIFO
// and drives STOP back upstream. Define SPI_RX_STATS_EN for WORD_CNT/DROP_CNT.
module input_process_spi_rx
  import spi_link_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STOP_MARGIN = 3
) (
  input logic                   CLK,
  input logic                   RST,
  input_process_spi_rx_if.slave bus
);

  word_t                  sr_q, capture_word;
  logic                   stop_q, stop_d, overflow_q, drop;
  logic [$clog2(DEPTH):0] level_next;

  // Framing comes only from RX_LOAD; the capture word includes the bit on the line now.
  assign capture_word = shift_in(sr_q, bus.RX_DATA);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_q <= '0;
    end else begin
      sr_q <= capture_word;
    end
  end

  sync_fifo_sa #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .wr_en      (bus.RX_LOAD),
    .wr_data    (capture_word),
    .rd_en      (bus.READY),
    .rd_data    (bus.DATA),
    .valid      (bus.VALID),
    .wr_drop    (drop),
    .level      (bus.LEVEL),
    .level_next (level_next)
  );

  // level_next never exceeds DEPTH, so the subtraction cannot wrap.
  assign stop_d = (DEPTH - 32'(level_next)) <= STOP_MARGIN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.STOP     = stop_q;
  assign bus.OVERFLOW = overflow_q;

`ifdef SPI_RX_STATS_EN
  logic [15:0] word_cnt_q, drop_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (bus.RX_LOAD) word_cnt_q <= word_cnt_q + 1'b1;
      if (drop)        drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign bus.WORD_CNT = word_cnt_q;
  assign bus.DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_input_process_spi_rx.sv
// Bench for input_process_spi_rx: directed scenarios plus random traffic checked
// against a queue-based model of the receiver.
module tb_input_process_spi_rx;
  import spi_link_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MARGIN = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  input_process_spi_rx_if #(.DEPTH(DEPTH)) bus ();

  input_process_spi_rx #(
    .DEPTH       (DEPTH),
    .STOP_MARGIN (MARGIN)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: words held by the receiver, the last 16 line bits, sticky drop flag, counts.
  logic [15:0] m_q[$];
  bit          m_bits[$];
  bit          m_ovf;
  int          m_words, m_drops;

  function automatic void model_clear();
    m_q.delete();
    m_bits.delete();
    m_ovf   = 1'b0;
    m_words = 0;
    m_drops = 0;
  endfunction

  // Apply the current inputs to the model, then advance one clock.
  task automatic cycle();
    bit          pop;
    logic [15:0] w;
    pop = (m_q.size() != 0) && (bus.READY === 1'b1);
    m_bits.push_back(bus.RX_DATA);
    if (m_bits.size() > 16) void'(m_bits.pop_front());
    if (pop) void'(m_q.pop_front());
    if (bus.RX_LOAD === 1'b1) begin
      w = '0;
      foreach (m_bits[i]) w = {w[14:0], m_bits[i]};
      m_words++;
      if (m_q.size() == DEPTH) begin
        m_ovf = 1'b1;
        m_drops++;
      end else begin
        m_q.push_back(w);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input bit rdy_last);
    bit saved = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      bus.RX_DATA = w[i];
      bus.RX_LOAD = (i == 0);
      if (i == 0 && rdy_last) begin
        saved     = bus.READY;
        bus.READY = 1'b1;
      end
      cycle();
    end
    bus.RX_DATA = 1'b0;
    bus.RX_LOAD = 1'b0;
    if (rdy_last) bus.READY = saved;
  endtask

  task automatic apply_reset();
    bus.RX_DATA = 1'b0;
    bus.RX_LOAD = 1'b0;
    bus.READY   = 1'b0;
    #2 RST = 1'b1;
    #1;
    model_clear();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    bus.RX_DATA = 1'b0;
    bus.RX_LOAD = 1'b0;
    bus.READY   = 1'b0;
    RST = 1'b1;
    #2;
    model_clear();
    checks += 5;
    if (bus.STOP !== 1'b0) begin
      errors++; $display("FAIL reset_stop: got %b want 0", bus.STOP);
    end
    if (bus.VALID !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", bus.VALID);
    end
    if (bus.DATA !== 16'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0000", bus.DATA);
    end
    if (bus.OVERFLOW !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b want 0", bus.OVERFLOW);
    end
    if (bus.LEVEL !== 5'd0) begin
      errors++; $display("FAIL reset_level: got %0d want 0", bus.LEVEL);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_single_word();
    apply_reset();
    bus.READY = 1'b1;
    send_word(16'hA5C3, 1'b0);
    checks += 3;
    if (bus.VALID !== 1'b1) begin
      errors++; $display("FAIL single_valid: got %b want 1", bus.VALID);
    end
    if (bus.DATA !== 16'hA5C3) begin
      errors++; $display("FAIL single_data: got %h want a5c3", bus.DATA);
    end
    if (bus.LEVEL !== 5'd1) begin
      errors++; $display("FAIL single_level: got %0d want 1", bus.LEVEL);
    end
    cycle();
    checks += 2;
    if (bus.VALID !== 1'b0) begin
      errors++; $display("FAIL single_pulse: valid got %b want 0", bus.VALID);
    end
    if (bus.LEVEL !== 5'd0) begin
      errors++; $display("FAIL single_drain: level got %0d want 0", bus.LEVEL);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'h0001;
    words[1] = 16'h8000;
    words[2] = 16'hFFFF;
    apply_reset();
    bus.READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_word(words[k], 1'b0);
      checks++;
      if (bus.VALID !== 1'b1 || bus.DATA !== words[k]) begin
        errors++;
        $display("FAIL b2b_word%0d: got valid=%b data=%h want valid=1 data=%h",
                 k, bus.VALID, bus.DATA, words[k]);
      end
    end
    cycle();
    checks += 2;
    if (bus.LEVEL !== 5'd0) begin
      errors++; $display("FAIL b2b_level: got %0d want 0", bus.LEVEL);
    end
    if (bus.OVERFLOW !== 1'b0) begin
      errors++; $display("FAIL b2b_overflow: got %b want 0", bus.OVERFLOW);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.READY = 1'b0;
    for (int k = 0; k < 12; k++) send_word(16'(k + 1), 1'b0);
    checks += 2;
    if (bus.STOP !== 1'b0) begin
      errors++; $display("FAIL bp_stop12: got %b want 0", bus.STOP);
    end
    if (bus.LEVEL !== 5'd12) begin
      errors++; $display("FAIL bp_level12: got %0d want 12", bus.LEVEL);
    end
    send_word(16'd13, 1'b0);
    checks += 2;
    if (bus.STOP !== 1'b1) begin
      errors++; $display("FAIL bp_stop13: got %b want 1", bus.STOP);
    end
    if (bus.LEVEL !== 5'd13) begin
      errors++; $display("FAIL bp_level13: got %0d want 13", bus.LEVEL);
    end
    for (int k = 13; k < 16; k++) send_word(16'(k + 1), 1'b0);
    checks += 3;
    if (bus.LEVEL !== 5'd16) begin
      errors++; $display("FAIL bp_level16: got %0d want 16", bus.LEVEL);
    end
    if (bus.OVERFLOW !== 1'b0) begin
      errors++; $display("FAIL bp_noovf: got %b want 0", bus.OVERFLOW);
    end
    if (bus.STOP !== 1'b1) begin
      errors++; $display("FAIL bp_stopfull: got %b want 1", bus.STOP);
    end
    send_word(16'hDEAD, 1'b0);
    checks += 3;
    if (bus.OVERFLOW !== 1'b1) begin
      errors++; $display("FAIL bp_ovf: got %b want 1", bus.OVERFLOW);
    end
    if (bus.LEVEL !== 5'd16) begin
      errors++; $display("FAIL bp_level_drop: got %0d want 16", bus.LEVEL);
    end
    if (bus.DATA !== 16'h0001) begin
      errors++; $display("FAIL bp_head: got %h want 0001", bus.DATA);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] head;
    apply_reset();
    bus.READY = 1'b0;
    for (int k = 0; k < 16; k++) send_word(16'h0100 + 16'(k), 1'b0);
    send_word(16'hBEEF, 1'b1);
    checks += 3;
    if (bus.LEVEL !== 5'd16) begin
      errors++; $display("FAIL fullpop_level: got %0d want 16", bus.LEVEL);
    end
    if (bus.OVERFLOW !== 1'b0) begin
      errors++; $display("FAIL fullpop_ovf: got %b want 0", bus.OVERFLOW);
    end
    if (bus.DATA !== 16'h0101) begin
      errors++; $display("FAIL fullpop_head: got %h want 0101", bus.DATA);
    end
    bus.READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      head = bus.DATA;
      checks++;
      if (head !== m_q[0]) begin
        errors++; $display("FAIL fullpop_drain%0d: got %h want %h", i, head, m_q[0]);
      end
      cycle();
    end
    checks += 2;
    if (head !== 16'hBEEF) begin
      errors++; $display("FAIL fullpop_tail: got %h want beef", head);
    end
    if (bus.VALID !== 1'b0) begin
      errors++; $display("FAIL fullpop_empty: valid got %b want 0", bus.VALID);
    end
  endtask

  task automatic test_reset_mid_word();
    apply_reset();
    bus.READY = 1'b0;
    send_word(16'hFACE, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bus.RX_DATA = 1'b1;
      cycle();
    end
    bus.RX_DATA = 1'b0;
    #2 RST = 1'b1;
    #1;
    model_clear();
    checks += 5;
    if (bus.STOP !== 1'b0) begin
      errors++; $display("FAIL midrst_stop: got %b want 0", bus.STOP);
    end
    if (bus.VALID !== 1'b0) begin
      errors++; $display("FAIL midrst_valid: got %b want 0", bus.VALID);
    end
    if (bus.DATA !== 16'h0) begin
      errors++; $display("FAIL midrst_data: got %h want 0000", bus.DATA);
    end
    if (bus.OVERFLOW !== 1'b0) begin
      errors++; $display("FAIL midrst_overflow: got %b want 0", bus.OVERFLOW);
    end
    if (bus.LEVEL !== 5'd0) begin
      errors++; $display("FAIL midrst_level: got %0d want 0", bus.LEVEL);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    send_word(16'h1234, 1'b0);
    checks += 2;
    if (bus.DATA !== 16'h1234) begin
      errors++; $display("FAIL midrst_word: got %h want 1234", bus.DATA);
    end
    if (bus.LEVEL !== 5'd1) begin
      errors++; $display("FAIL midrst_level1: got %0d want 1", bus.LEVEL);
    end
  endtask

`ifdef SPI_RX_STATS_EN
  task automatic test_stats();
    apply_reset();
    bus.READY = 1'b0;
    for (int k = 0; k < 20; k++) send_word(16'($urandom), 1'b0);
    checks += 2;
    if (bus.WORD_CNT !== 16'd20) begin
      errors++; $display("FAIL stats_words: got %0d want 20", bus.WORD_CNT);
    end
    if (bus.DROP_CNT !== 16'd4) begin
      errors++; $display("FAIL stats_drops: got %0d want 4", bus.DROP_CNT);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] exp_data;
    bit          exp_stop;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      bus.RX_DATA = 1'($urandom);
      bus.RX_LOAD = ($urandom_range(0, 5) == 0);
      bus.READY   = ($urandom_range(0, 99) < ((i % 200) < 100 ? 10 : 70));
      cycle();
      exp_data = (m_q.size() != 0) ? m_q[0] : 16'h0;
      exp_stop = (int'(DEPTH) - m_q.size()) <= int'(MARGIN);
      checks++;
      if (bus.VALID !== (m_q.size() != 0) || bus.DATA !== exp_data ||
          bus.LEVEL !== 5'(m_q.size()) || bus.STOP !== exp_stop ||
          bus.OVERFLOW !== m_ovf) begin
        errors++;
        $display("FAIL rand_cyc%0d: got v=%b d=%h l=%0d s=%b o=%b want v=%b d=%h l=%0d s=%b o=%b",
                 i, bus.VALID, bus.DATA, bus.LEVEL, bus.STOP, bus.OVERFLOW,
                 m_q.size() != 0, exp_data, m_q.size(), exp_stop, m_ovf);
      end
`ifdef SPI_RX_STATS_EN
      checks++;
      if (bus.WORD_CNT !== 16'(m_words) || bus.DROP_CNT !== 16'(m_drops)) begin
        errors++;
        $display("FAIL rand_stats%0d: got w=%0d d=%0d want w=%0d d=%0d",
                 i, bus.WORD_CNT, bus.DROP_CNT, m_words, m_drops);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_full_pop();
    test_reset_mid_word();
`ifdef SPI_RX_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_process_spi_rx.md
Name: input_process_spi_rx

Overview:
- Downstream receiving stage for the SPI output path: deserializes the serial bit stream (TX_DATA/TX_LOAD of the output stage) back into 16-bit words.
- Buffers words in a local FIFO and presents them on a valid/ready interface.
- Drives STOP back to the transmitter's RX_STOP input so the sender pauses before the buffer overflows.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, 4..256.
- STOP_MARGIN, 3, free-slot threshold; STOP asserts when free slots <= STOP_MARGIN. Must cover words already in flight.

Ports:
- CLK  in  1  single clock, same domain as the transmitter's TX_CLK
- RST  in  1  asynchronous, active-high reset
- RX_DATA  in  1  serial data, MSB first, one bit per CLK
- RX_LOAD  in  1  high on the cycle carrying the final (LSB) bit of a word
- STOP  out  1  flow control to the upstream stage (its RX_STOP)
- DATA  out  16  head-of-FIFO word
- VALID  out  1  DATA holds a word
- READY  in  1  consumer accepts DATA when VALID & READY
- OVERFLOW  out  1  sticky; a word was dropped
- LEVEL  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: asynchronous, active-high, one clock, as decided.
  - Reset values: STOP=0, VALID=0, DATA=0, OVERFLOW=0, LEVEL=0.
  - Shift register, FIFO pointers and counters are cleared.
  - Reset mid-word discards the partial word; nothing is written.
- Shift register (16 bit):
  - Shifts every cycle: sr <= {sr[14:0], RX_DATA}.
  - No bit counter; framing is defined solely by RX_LOAD. Idle gaps between words are tolerated.
- Capture: at an edge with RX_LOAD=1, the word {sr[14:0], RX_DATA} is written into the FIFO at that same edge.
  - If fewer than 16 bits have arrived since reset, the word contains the leftover/zero bits. No error is flagged.
- FIFO is show-ahead:
  - A write into an empty FIFO gives VALID=1 and DATA=word on the next cycle, i.e. one cycle after the capture edge.
  - Pop occurs on VALID & READY; the next word, if any, appears in the following cycle with no bubble.
- Full:
  - Capture while LEVEL==DEPTH and no pop in the same cycle: word dropped, OVERFLOW set (cleared only by RST), FIFO contents untouched.
  - Capture and pop in the same cycle when full: both happen, no drop, LEVEL unchanged.
- Empty: READY while VALID=0 is ignored; LEVEL never underflows.
- LEVEL:
  - +1 on write only, -1 on pop only, unchanged on both or neither.
  - Registered; updated on the same edge as the pointers.
- STOP:
  - Registered: STOP <= (DEPTH - LEVEL_next) <= STOP_MARGIN.
  - Asserts one cycle after the threshold is crossed and deasserts one cycle after occupancy drops below it.
  - Must be high whenever the FIFO is full (guaranteed because STOP_MARGIN >= 1).
- Pointers: $clog2(DEPTH) bits, natural wrap-around; LEVEL tracks full/empty unambiguously.

Optional Feature:
- Macro: SPI_RX_STATS_EN.
- With it defined: two extra outputs.
  - WORD_CNT[15:0]: counts every RX_LOAD capture, including dropped words.
  - DROP_CNT[15:0]: counts dropped words.
  - Both wrap at 16'hFFFF -> 0 and reset to 0.
- Without it: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package spi_link_pkg: WORD_W=16 and the bit-order constant (MSB first).
  - The output stage's serializer also uses this package.
- One sub-module: sync_fifo_sa (show-ahead synchronous FIFO), with DEPTH/width parameters, a level output and async active-high RST.
- Shift/capture logic, STOP logic and stats stay in input_process_spi_rx.

Test Plan:
- Single word: shift 16'hA5C3 MSB first with RX_LOAD on bit 16, READY=1 -> VALID one cycle after the capture edge, DATA=16'hA5C3, one-cycle pulse, LEVEL returns to 0.
- Back-to-back: words 16'h0001, 16'h8000, 16'hFFFF with no idle gap, READY=1 -> three words out in order, no loss, OVERFLOW=0.
- Backpressure: READY=0, DEPTH=16, STOP_MARGIN=3, send 13 words -> STOP=1 one cycle after the 13th capture, LEVEL=13. Send 3 more -> LEVEL=16, no drop. 17th word -> dropped, OVERFLOW=1, head DATA unchanged.
- Full with simultaneous pop: LEVEL=16, capture and READY=1 on the same edge -> LEVEL stays 16, OVERFLOW stays 0, last-written word is the new tail.
- Reset mid-word: RST pulsed after 7 bits -> all outputs 0. Next full 16'h1234 frame -> DATA=16'h1234.
- With SPI_RX_STATS_EN: 20 words into DEPTH=16 with READY=0 -> WORD_CNT=20, DROP_CNT=4.
